// File: rtl/scalar_wb_ctrl.sv
// scalar_wb_ctrl: round-robin write-back arbiter and RAW/WAW scoreboard for the scalar register file
module scalar_wb_ctrl #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 3,
  parameter int NREG  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  input  logic [4:0]            alloc_rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [4:0]            rs3,
  output logic                  stall,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*5-1:0]     req_rd,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [4:0]            RD,
  output logic [255:0]          WD,
  output logic                  WES,
  output logic [NREG-1:0]       busy,
  output logic                  err_unalloc
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  logic [PW-1:0]   ptr, gnt;
  logic            hit;
  int              idx;
  logic [NREG-1:0] busy_nxt;
  assign stall = busy[rs1] | busy[rs2] | busy[rs3] | (alloc_valid & busy[alloc_rd]);
  // Scan from lowest priority to highest so the last match is the winner.
  always_comb begin
    gnt = '0;
    hit = 1'b0;
    idx = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        hit = 1'b1;
        gnt = PW'(idx);
      end
    end
  end
  assign req_ready = (hit && rst) ? NREQ'(1) << gnt : '0;
  // Clear lands on the edge the RF captures the data; a colliding set wins.
  always_comb begin
    busy_nxt = busy;
    if (WES) busy_nxt[RD] = 1'b0;
    if (alloc_valid && !stall) busy_nxt[alloc_rd] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy        <= '0;
      RD          <= '0;
      WD          <= '0;
      WES         <= 1'b0;
      err_unalloc <= 1'b0;
      ptr         <= '0;
    end else begin
      busy <= busy_nxt;
      WES  <= hit;
      if (WES && !busy[RD]) err_unalloc <= 1'b1;
      if (hit) begin
        RD  <= req_rd[5*gnt +: 5];
        WD  <= {req_data[WIDTH*gnt +: WIDTH], {(256-WIDTH){1'b0}}};
        ptr <= (gnt == PW'(NREQ - 1)) ? '0 : gnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/scalar_wb_ctrl.md
Name: scalar_wb_ctrl

Overview:
Write-back controller and hazard scoreboard for the 32-entry scalar register file. It arbitrates up to NREQ write-back requesters (ALU, load unit, vector-reduce unit) onto the single RF write port (RD/WD/WES) using round-robin. It also tracks per-register pending writes so the issue stage stalls on RAW/WAW hazards. It sits between the execute/memory units and the scalar register file.

Parameters:
WIDTH, 16, scalar data width
NREQ, 3, number of write-back requesters (verified at 3)
NREG, 32, number of scalar registers; index width fixed at 5

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
alloc_valid  in  1  issue stage requests reservation of alloc_rd
alloc_rd  in  5  destination register to reserve
rs1  in  5  source register 1 of instruction in issue
rs2  in  5  source register 2
rs3  in  5  source register 3
stall  out  1  issue must hold; combinational
req_valid  in  NREQ  write-back request per requester
req_rd  in  NREQ*5  destination per requester; slice i is [5i+4:5i]
req_data  in  NREQ*WIDTH  data per requester; slice i is [WIDTH*i+WIDTH-1:WIDTH*i]
req_ready  out  NREQ  grant, one-hot or zero; combinational
RD  out  5  RF write address, registered
WD  out  256  RF write data, registered
WES  out  1  RF write enable, registered
busy  out  NREG  scoreboard vector, registered
err_unalloc  out  1  sticky flag: write-back to a non-busy register

Behaviour:
- Reset (rst=0, async): busy=0, RD=0, WD=0, WES=0, err_unalloc=0, rr pointer=0. Any in-flight write held in the output register is dropped.
- Stall logic: stall = busy[rs1] | busy[rs2] | busy[rs3] | (alloc_valid & busy[alloc_rd]).
  - stall is evaluated every cycle, independent of alloc_valid for the source terms.
- Allocation: at the clock edge where alloc_valid=1 and stall=0, busy[alloc_rd] is set.
  - Allocation while stall=1 has no effect.
- Arbitration:
  - Round-robin pointer ptr gives the highest-priority requester.
  - Grant goes to the first i with req_valid[i]=1, searching ptr, ptr+1, ... modulo NREQ.
  - req_ready[grant]=1 in the same cycle; transfer occurs on req_valid & req_ready.
  - At most one grant per cycle.
  - After a grant to i, ptr=(i+1) mod NREQ. With no request, ptr holds.
  - The arbiter is never back-pressured by the RF, so a single requester with valid held high is granted every cycle.
- Write port, latency 1:
  - At the edge of a transfer: RD<=req_rd[i], WD[255:256-WIDTH]<=req_data[i], WD[255-WIDTH:0]<=0, WES<=1.
  - Otherwise WES<=0, and RD/WD hold their values.
- Scoreboard clear: busy[RD] is cleared at the edge where WES=1, which is the same edge the RF captures the data.
  - An issue-stage read is released only once the RF holds the new value.
  - Total handshake-to-busy-clear delay is 2 edges.
- Same-edge set and clear of one index cannot occur legally, since WAW stalls the allocation. If it does occur, set wins.
- Unallocated write: if WES=1 and busy[RD]=0 at an edge, the write still happens and err_unalloc<=1. err_unalloc holds until reset.
- Requesters must hold req_valid, req_rd and req_data stable until accepted. The block does not check this.

Test Plan:
- Reset mid-write: drive req_valid[0]=1 (rd=5, data=16'hBEEF); pulse rst low while WES=1 -> WES=0, busy=0, err_unalloc=0 immediately, asynchronously; no grant until rst=1.
- RAW stall: alloc_rd=7 accepted; then rs1=7 -> stall=1. req 1 writes rd=7, data=16'h1234 -> WES=1, RD=7, WD[255:240]=16'h1234 one edge later; busy[7] clears the following edge; stall drops the same cycle.
- WAW: busy[3]=1; alloc_valid=1, alloc_rd=3 -> stall=1, busy unchanged; after write-back of r3 completes, the allocation is accepted and busy[3]=1 again.
- Round-robin fairness: all three req_valid high for 6 cycles with ptr=0 at start -> grant order 0,1,2,0,1,2; RD sequence on the write port matches, one cycle delayed.
- Partial contention: req_valid=3'b101 with ptr=1 -> grant 2, then ptr=0 -> grant 0, then grant 2.
- Unallocated write: busy=0; req 2 writes rd=9 -> WES=1, RD=9, err_unalloc=1 and stays 1 through subsequent legal writes until reset.
